instr_fetch_unit: RTL

//   Consumer side of the program-counter interface. Holds the fetch PC and

---
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one memory read at a time,
// and buffers {pc, instr} pairs in a small FIFO toward decode.
//
// state | meaning
// IDLE  | FIFO full, waiting for decode to free a slot
// REQ   | read request presented at pc
// WAIT  | request accepted, waiting for its response
// DROP  | a redirect orphaned an accepted request; swallow its response
module instr_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t              state_q, state_d;
  logic                req_valid_q;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
  logic [CNT_W-1:0]    count_q, count_nxt;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [ADDR_W-1:0]   fifo_pc_q    [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_instr_q [FIFO_DEPTH];

  logic                req_fire, push, pop, space;
  logic [ADDR_W-1:0]   redirect_pc_al;
  logic                unused_rpc;

  assign unused_rpc     = ^redirect_pc[1:0];
  assign redirect_pc_al = {redirect_pc[ADDR_W-1:2], 2'b00};

  assign req_fire  = req_valid_q & mem_req_ready;
  assign pop       = (count_q != '0) & out_ready;
  assign push      = (state_q == WAIT) & mem_rsp_valid & ~redirect_valid;
  assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);
  // Space is judged after this cycle's push/pop so the single outstanding
  // response can always land.
  assign space     = count_nxt < CNT_W'(FIFO_DEPTH);

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = pc_q;
  assign pc            = pc_q;
  assign out_valid     = (count_q != '0);
  assign out_pc        = fifo_pc_q[rd_ptr_q];
  assign out_instr     = fifo_instr_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc_al;
      unique case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = req_fire ? DROP : REQ;
        WAIT:    state_d = mem_rsp_valid ? REQ : DROP;
        DROP:    state_d = mem_rsp_valid ? REQ : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: if (space) state_d = REQ;
        REQ: begin
          if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + ADDR_W'(4);
            state_d  = WAIT;
          end
        end
        WAIT:    if (mem_rsp_valid) state_d = space ? REQ : IDLE;
        DROP:    if (mem_rsp_valid) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      req_valid_q <= (state_d == REQ);
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      if (redirect_valid) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        count_q <= count_nxt;
        if (push) begin
          fifo_pc_q[wr_ptr_q]    <= req_pc_q;
          fifo_instr_q[wr_ptr_q] <= mem_rsp_data;
          wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule
